// File: rtl/inputc_req_pkg.sv
// Shared constants and types for the router input-channel controller.
// Flit type lives in the top two bits: bit 0 of the type marks a head, bit 1 marks a tail.
package inputc_req_pkg;

    localparam int unsigned PORT    = 5;
    localparam int unsigned PORTW   = 2;
    localparam int unsigned PORT_P1 = PORT + 1;

    localparam logic [1:0] FT_BODY = 2'b00;
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b10;
    localparam logic [1:0] FT_HT   = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StSettle,
        StActive,
        StDrop
    } state_e;

    function automatic logic is_head(input logic [1:0] ft);
        return ft[0];
    endfunction

    function automatic logic is_tail(input logic [1:0] ft);
        return ft[1];
    endfunction

endpackage

// File: rtl/inputc_req_flit_fifo.sv
// Synchronous flit FIFO; the front entry is visible combinationally, with no
// write-to-read bypass, so a flit pushed into an empty FIFO appears one cycle later.
module inputc_req_flit_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] front,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign front   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/inputc_req.sv
// Router input-channel controller: buffers flits, requests the output named by the
// head flit, waits for that output's grant, then streams the packet up to its tail.
module inputc_req
    import inputc_req_pkg::*;
#(
    parameter int unsigned PORTID = 0,
    parameter int unsigned DATAW  = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DATAW+1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PORTW:0]   port,
    output logic             req,
    input  logic [PORT:0]    grt,
    output logic [DATAW+1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    state_e           state_q, state_d;
    logic [PORTW:0]   port_q, port_d;
    logic             first_q, first_d;
    logic             err_q, err_d;
    logic             push, pop, full, empty;
    logic [DATAW+1:0] front;
    logic [1:0]       ft;
    logic             unused_portid;

    assign unused_portid = ^3'(PORTID);

    inputc_req_flit_fifo #(
        .WIDTH (DATAW + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .front (front),
        .full  (full),
        .empty (empty)
    );

    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign ft       = front[DATAW+1:DATAW];
    assign port     = port_q;
    assign err      = err_q;

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        first_d   = first_q;
        err_d     = 1'b0;
        pop       = 1'b0;
        req       = 1'b0;
        out_valid = 1'b0;
        out_data  = front;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    if (is_head(ft)) begin
                        port_d = front[PORTW:0];
                        if (front[PORTW:0] > (PORTW+1)'(PORT)) begin
                            state_d = StDrop;
                            err_d   = 1'b1;
                        end else begin
                            state_d = StReq;
                        end
                    end else begin
                        pop   = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            StReq: begin
                req = 1'b1;
                if (grt[port_q]) state_d = StSettle;
            end
            StSettle: begin
                // Mux select is registered off the grant, so wait one cycle before sending.
                req     = 1'b1;
                first_d = 1'b1;
                state_d = StActive;
            end
            StActive: begin
                req       = 1'b1;
                out_valid = ~empty;
                // Only the packet's own head may leave as a head; strays are demoted.
                if (!first_q && is_head(ft)) out_data[DATAW] = 1'b0;
                if (out_valid && out_ready) begin
                    pop     = 1'b1;
                    first_d = 1'b0;
                    if (!first_q && is_head(ft)) err_d = 1'b1;
                    if (is_tail(ft)) state_d = StIdle;
                end
            end
            StDrop: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (is_tail(ft)) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            port_q  <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

endmodule
